// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose: time-shares one purely combinational ALU between NUM_REQ requesting
// pipeline stages. The block picks a requester, registers its operands and
// opcode onto the ALU inputs, captures the ALU result and flags one cycle
// later, and returns them on a per-requester response handshake.
//
// Optional build macro: ALU_ARB_PRIO0_EN
//   undefined : pure round-robin across all requesters.
//   defined   : requester 0 has strict priority and does not move the
//               round-robin pointer; the others round-robin among themselves.
//
// Handshakes (valid/ready):
//   Request : a transfer happens on a rising edge where req_valid[i] and
//             req_ready[i] are both 1. req_ready is one-hot and is only
//             raised in IDLE. A requester holds valid and operands until
//             ready; dropping valid earlier simply withdraws the request.
//   Response: rsp_valid[g] is one-hot. It completes on the rising edge where
//             rsp_valid[g] and rsp_ready[g] are both 1; rsp_result and
//             rsp_flags stay constant while rsp_valid[g] waits. rsp_ready
//             bits of other requesters are ignored.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid/ready       per-requester request handshake
//   req_a/req_b/req_op    packed per-requester operands and opcode
//   rsp_valid/ready       per-requester response handshake
//   rsp_result/rsp_flags  shared result bus, flags {N, C, V, Z}
//   alu_a/alu_b/alu_ctrl  registered inputs to the external ALU
//   alu_result, alu_*     combinational outputs of the external ALU
//   dbg_state             current FSM state (IDLE=0, EXEC=1, RESP=2)
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [3:0]                rsp_flags,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  input  logic                      alu_ovf,
  input  logic                      alu_carry,
  input  logic                      alu_neg,
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]    alu_a_q, alu_a_d;
  logic [DATA_W-1:0]    alu_b_q, alu_b_d;
  logic [OP_W-1:0]      alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_moves_ptr;

  // (p + k) mod NUM_REQ for k in 0..NUM_REQ; avoids a real divider.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Winner: first valid requester at or after the pointer, wrapping.
  always_comb begin
    win_found     = 1'b0;
    win_idx       = '0;
    win_moves_ptr = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[wrap_add(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, k);
      end
    end
`ifdef ALU_ARB_PRIO0_EN
    // Requester 0 overrides the rotation and leaves the pointer alone so the
    // other requesters keep their fair order.
    if (req_valid[0]) begin
      win_found     = 1'b1;
      win_idx       = '0;
      win_moves_ptr = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    result_d    = result_q;
    flags_d     = flags_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          alu_a_d    = req_a[int'(win_idx)*DATA_W +: DATA_W];
          alu_b_d    = req_b[int'(win_idx)*DATA_W +: DATA_W];
          alu_ctrl_d = req_op[int'(win_idx)*OP_W +: OP_W];
          grant_d    = win_idx;
          if (win_moves_ptr) ptr_d = wrap_add(win_idx, 1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d              = alu_result;
        flags_d               = {alu_neg, alu_carry, alu_ovf, alu_zero};
        rsp_valid_d           = '0;
        rsp_valid_d[grant_q]  = 1'b1;
        state_d               = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_valid  = rsp_valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Bench for alu_share_arbiter (4 requesters, 32-bit data, 6-bit opcode).
// A behavioural ALU is attached to the alu_* ports. The reference model
// tracks the arbitration pointer as a plain integer, picks the expected
// winner by scanning the request vector, and predicts the response from the
// winner's operands. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 6;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_CMP = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0]   rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]      rsp_flags;
  logic [OW-1:0]   alu_ctrl;
  logic            alu_zero, alu_ovf, alu_carry, alu_neg;
  logic [1:0]      dbg_state;

  logic [DW-1:0] ta [N];
  logic [DW-1:0] tbv[N];
  logic [OW-1:0] top[N];

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW]  = ta[i];
      req_b[i*DW +: DW]  = tbv[i];
      req_op[i*OW +: OW] = top[i];
    end
  end

  alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .alu_carry(alu_carry), .alu_neg(alu_neg),
    .dbg_state(dbg_state)
  );

  // Behavioural ALU: returns {N, C, V, Z, result}. C is "no borrow" on subtract.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB, OP_CMP: begin
        w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = ~w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return {r[31], c, v, (r == 32'd0), r};
  endfunction

  logic [35:0] alu_out;
  assign alu_out    = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_result = alu_out[31:0];
  assign {alu_neg, alu_carry, alu_ovf, alu_zero} = alu_out[35:32];

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  logic [N-1:0] after_valid;
  bit rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
`ifdef ALU_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  // Requester behaviour once its request has been accepted.
  task automatic refresh(input int g);
    if (rand_mode) begin
      ta[g]  = $urandom;
      tbv[g] = ($urandom_range(0, 3) == 0) ? ta[g] : $urandom;
      top[g] = 6'($urandom_range(0, 5));
      req_valid = 4'($urandom_range(0, 15));
    end else begin
      req_valid = after_valid;
    end
  endtask

  // One complete operation, entered and left at a falling edge in IDLE.
  task automatic run_op(input int hold, output int g_o,
                        output logic [31:0] res_o, output logic [3:0] fl_o);
    int          g;
    logic [35:0] e;
    logic [3:0]  oh;
    logic [31:0] ea, eb;
    logic [5:0]  eo;
    #1;
    g  = model_pick(req_valid, m_ptr);
    oh = 4'b0001 << g;
    ea = ta[g]; eb = tbv[g]; eo = top[g];
    e  = alu_fn(ea, eb, eo);
`ifdef ALU_ARB_PRIO0_EN
    if (!req_valid[0]) m_ptr = (g + 1) % N;
`else
    m_ptr = (g + 1) % N;
`endif
    chk("req_ready_idle", 64'(req_ready), 64'(oh));
    @(posedge clk); @(negedge clk);
    chk("req_ready_exec", 64'(req_ready), 64'd0);
    chk("rsp_valid_exec", 64'(rsp_valid), 64'd0);
    chk("alu_a", 64'(alu_a), 64'(ea));
    chk("alu_b", 64'(alu_b), 64'(eb));
    chk("alu_ctrl", 64'(alu_ctrl), 64'(eo));
    refresh(g);
    @(posedge clk); @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_result", 64'(rsp_result), 64'(e[31:0]));
    chk("rsp_flags", 64'(rsp_flags), 64'(e[35:32]));
    g_o = g; res_o = rsp_result; fl_o = rsp_flags;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 4'($urandom) & ~oh;
      @(posedge clk); @(negedge clk);
      chk("rsp_valid_hold", 64'(rsp_valid), 64'(oh));
      chk("rsp_result_hold", 64'(rsp_result), 64'(e[31:0]));
      chk("rsp_flags_hold", 64'(rsp_flags), 64'(e[35:32]));
      chk("req_ready_hold", 64'(req_ready), 64'd0);
    end
    rsp_ready = 4'($urandom) | oh;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;
    chk("rsp_valid_done", 64'(rsp_valid), 64'd0);
    chk("alu_a_kept", 64'(alu_a), 64'(ea));
    chk("alu_ctrl_kept", 64'(alu_ctrl), 64'(eo));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  int          g;
  logic [31:0] r;
  logic [3:0]  f;
  int          exp_c[5];
  int          exp_e[4];
  logic [31:0] exp_res_c[4];

  initial begin
`ifdef ALU_ARB_PRIO0_EN
    exp_c = '{0, 0, 0, 0, 0};
    exp_e = '{0, 0, 0, 0};
`else
    exp_c = '{0, 1, 2, 3, 0};
    exp_e = '{0, 2, 0, 2};
`endif
    exp_res_c = '{32'd15, 32'hFFFFFFFB, 32'h0F000F00, 32'hFF0FFF0F};

    for (int i = 0; i < N; i++) begin ta[i] = '0; tbv[i] = '0; top[i] = '0; end
    req_valid = '0; rsp_ready = '0; after_valid = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_alu_a", 64'(alu_a), 64'd0);
    chk("reset_alu_b", 64'(alu_b), 64'd0);
    chk("reset_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_flags", 64'(rsp_flags), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Requester 1 alone: ADD 10 + 5, response accepted immediately.
    ta[1] = 32'd10; tbv[1] = 32'd5; top[1] = OP_ADD;
    req_valid = 4'b0010; rsp_ready = 4'b0010; after_valid = 4'b0000;
    run_op(0, g, r, f);
    chk("t1_grant", 64'(g), 64'd1);
    chk("t1_result", 64'(r), 64'd15);
    chk("t1_flags", 64'(f), 64'd0);

    // Requester 2: SUB 15 - 20 gives a negative result.
    ta[2] = 32'd15; tbv[2] = 32'd20; top[2] = OP_SUB;
    req_valid = 4'b0100;
    run_op(0, g, r, f);
    chk("t2_grant", 64'(g), 64'd2);
    chk("t2_result", 64'(r), 64'hFFFFFFFB);
    chk("t2_neg", 64'(f[3]), 64'd1);
    chk("t2_zero", 64'(f[0]), 64'd0);
    chk("t2_flags", 64'(f), 64'b1000);

    // Reset while the operation is in EXEC: aborted, nothing delivered.
    ta[2] = 32'd7; tbv[2] = 32'd9; top[2] = OP_ADD;
    req_valid = 4'b0100;
    #1;
    chk("rstx_req_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("rstx_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstx_alu_a", 64'(alu_a), 64'd0);
    chk("rstx_alu_b", 64'(alu_b), 64'd0);
    chk("rstx_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rstx_rsp_result", 64'(rsp_result), 64'd0);
    chk("rstx_rsp_flags", 64'(rsp_flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    chk("rstx_no_response", 64'(rsp_valid), 64'd0);

    // All four continuously valid with distinct ops.
    ta[0] = 32'd10;         tbv[0] = 32'd5;          top[0] = OP_ADD;
    ta[1] = 32'd15;         tbv[1] = 32'd20;         top[1] = OP_SUB;
    ta[2] = 32'hFF00FF00;   tbv[2] = 32'h0F0F0F0F;   top[2] = OP_AND;
    ta[3] = 32'hFF00FF00;   tbv[3] = 32'h0F0F0F0F;   top[3] = OP_OR;
    req_valid = 4'b1111; after_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_op(0, g, r, f);
      chk("all_grant", 64'(g), 64'(exp_c[i]));
      chk("all_result", 64'(r), 64'(exp_res_c[exp_c[i]]));
    end
    req_valid = '0;

    // Requester 0 CMP held for 5 cycles; requester 3 arrives meanwhile.
    ta[0] = 32'd8; tbv[0] = 32'd12; top[0] = OP_CMP;
    ta[3] = 32'd3; tbv[3] = 32'd4;  top[3] = OP_ADD;
    req_valid = 4'b0001; after_valid = 4'b1000;
    run_op(5, g, r, f);
    chk("cmp_grant", 64'(g), 64'd0);
    chk("cmp_result", 64'(r), 64'hFFFFFFFC);
    chk("cmp_flags", 64'(f), 64'b1000);
    after_valid = 4'b0000;
    run_op(0, g, r, f);
    chk("late3_grant", 64'(g), 64'd3);
    chk("late3_result", 64'(r), 64'd7);

    // Requesters 0 and 2 continuously valid.
    req_valid = 4'b0101; after_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      run_op(0, g, r, f);
      chk("pair_grant", 64'(g), 64'(exp_e[i]));
    end
    req_valid = '0;

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < N; i++) begin
      ta[i] = $urandom; tbv[i] = $urandom; top[i] = 6'($urandom_range(0, 5));
    end
    req_valid = 4'($urandom_range(1, 15));
    for (int n = 0; n < 40; n++) begin
      if (req_valid == '0) req_valid = 4'($urandom_range(1, 15));
      run_op($urandom_range(0, 3), g, r, f);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
